// File: rtl/cpu_fetch_unit_pkg.sv
// rtl/cpu_fetch_unit_pkg.sv - shared types and constants for the instruction-fetch front end
package pkg_cpu_typedefs;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/cpu_fetch_unit_if.sv
// rtl/cpu_fetch_unit_if.sv - instruction-memory req/gnt/rvalid bus
interface cpu_fetch_unit_if
    import pkg_cpu_typedefs::*;
#(
    parameter int ADDR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/cpu_fetch_unit_fifo.sv
// rtl/cpu_fetch_unit_fifo.sv - prefetch buffer of {instr, pc} entries
module cpu_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [W-1:0]     i_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full,
    output logic [W-1:0]     o_head
);
    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset: o_head is only consumed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/cpu_fetch_unit.sv
// rtl/cpu_fetch_unit.sv - RV32I fetch front end: PC generation, imem requests, prefetch FIFO, redirect drain
module cpu_fetch_unit
    import pkg_cpu_typedefs::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    cpu_fetch_unit_if.master    imem,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                instr_ready,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [6:0]          opc,
    output logic [2:0]          funct3,
    output logic                funct7,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_plus4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int ENT_W = INSTR_W + ADDR_W;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    fetch_state_t       r_state;
    logic               r_req;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_resp_pc;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   r_drop;

    fetch_state_t       w_state_nxt;
    logic               w_gnt;
    logic               w_pend_nxt;
    logic               w_push;
    logic               w_pop;
    logic               w_credit_ok;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [CNT_W-1:0]   w_fifo_count;
    logic [CNT_W-1:0]   w_out_nxt;
    logic [CNT_W-1:0]   w_drop_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ADDR_W-1:0]  w_target;
    logic [ADDR_W-1:0]  w_base_pc;
    logic [ENT_W-1:0]   w_head;
    logic [INSTR_W-1:0] w_head_instr;
    logic [ADDR_W-1:0]  w_head_pc;

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_addr;

    assign w_gnt      = r_req && imem.imem_gnt;
    assign w_pend_nxt = r_req && !imem.imem_gnt;
    assign w_target   = redirect_pc & ~(ADDR_W'(3));
    assign w_base_pc  = redirect ? w_target : r_fetch_pc;

    assign instr_valid = !w_fifo_empty && !redirect;
    assign w_pop       = instr_valid && instr_ready;
    assign w_push      = imem.imem_rvalid && (r_drop == '0) && !redirect && !w_fifo_full;

    cpu_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_data  ({imem.imem_rdata, r_resp_pc}),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_head  (w_head)
    );

    assign w_head_instr = w_head[ADDR_W +: INSTR_W];
    assign w_head_pc    = w_head[ADDR_W-1:0];

    assign instr    = instr_valid ? w_head_instr : RV_NOP;
    assign opc      = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[30];
    assign pc       = instr_valid ? w_head_pc : r_resp_pc;
    assign pc_plus4 = pc + PC_STEP;

    always_comb begin
        w_out_nxt   = r_outstanding + CNT_W'(w_gnt) - CNT_W'(imem.imem_rvalid);
        w_cnt_nxt   = redirect ? '0 : (w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop));
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        if (redirect) begin
            // Everything still in flight is stale, including a pending ungranted request.
            w_drop_nxt  = w_out_nxt;
            w_state_nxt = ((w_out_nxt != '0) || w_pend_nxt) ? DRAIN : FETCH;
        end else begin
            if ((r_state == DRAIN) && w_gnt)          w_drop_nxt = w_drop_nxt + CNT_W'(1);
            if (imem.imem_rvalid && (r_drop != '0))   w_drop_nxt = w_drop_nxt - CNT_W'(1);
            case (r_state)
                BOOT:    w_state_nxt = FETCH;
                FETCH:   w_state_nxt = FETCH;
                DRAIN:   if ((w_drop_nxt == '0) && !w_pend_nxt) w_state_nxt = FETCH;
                default: w_state_nxt = BOOT;
            endcase
        end
        w_credit_ok = (SUM_W'(w_out_nxt) + SUM_W'(w_cnt_nxt)) < SUM_W'(FIFO_DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_req         <= 1'b0;
            r_addr        <= RESET_PC;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_out_nxt;
            r_drop        <= w_drop_nxt;

            if (redirect)    r_resp_pc <= w_target;
            else if (w_push) r_resp_pc <= r_resp_pc + PC_STEP;

            // An ungranted request keeps req/addr frozen; only the next fetch target moves.
            if (w_pend_nxt) begin
                r_fetch_pc <= w_base_pc;
            end else if ((w_state_nxt == FETCH) && w_credit_ok) begin
                r_req      <= 1'b1;
                r_addr     <= w_base_pc;
                r_fetch_pc <= w_base_pc + PC_STEP;
            end else begin
                r_req      <= 1'b0;
                r_fetch_pc <= w_base_pc;
            end
        end
    end
endmodule

// File: tb/tb_cpu_fetch_unit.sv
// tb/tb_cpu_fetch_unit.sv - scoreboard bench for cpu_fetch_unit
module tb_cpu_fetch_unit;
    import pkg_cpu_typedefs::*;

    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    logic        gnt_en;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    int          lat;
    int          cyc;

    int checks   = 0;
    int errors   = 0;
    int consumed = 0;
    int grants   = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr[$];

    always #5 clk = ~clk;

    cpu_fetch_unit_if #(.ADDR_W(ADDR_W)) imem_if ();

    assign imem_if.imem_gnt    = gnt_en;
    assign imem_if.imem_rvalid = m_rvalid && rst_n;
    assign imem_if.imem_rdata  = m_rdata;

    cpu_fetch_unit #(
        .ADDR_W     (ADDR_W),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem_if),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .opc         (opc),
        .funct3      (funct3),
        .funct7      (funct7),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[29:2], a[5:2]} ^ 32'h4000_5033;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_stream(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(base + 32'(4 * i));
            exp_addr.push_back(base + 32'(4 * i));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},      32'(imem_if.imem_req), 32'h0);
        chk({tag, "_addr"},     imem_if.imem_addr,     32'h0);
        chk({tag, "_valid"},    32'(instr_valid),      32'h0);
        chk({tag, "_instr"},    instr,                 RV_NOP);
        chk({tag, "_pc"},       pc,                    32'h0);
        chk({tag, "_pc_plus4"}, pc_plus4,              32'h4);
    endtask

    task automatic wait_consumed(input int target, input string name);
        int n = 0;
        while (consumed < target && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk(name, 32'(consumed >= target), 32'h1);
    endtask

    // Called at #2 after a posedge; returns at #2 after the following posedge.
    task automatic do_redirect(input logic [31:0] tgt, input logic [31:0] aligned);
        logic [31:0] keep;
        redirect    = 1'b1;
        redirect_pc = tgt;
        exp_q.delete();
        if (imem_if.imem_req && exp_addr.size() > 0) begin
            keep = exp_addr[0];
            exp_addr.delete();
            exp_addr.push_back(keep);
        end else begin
            exp_addr.delete();
        end
        push_stream(aligned, 32);
        @(negedge clk);
        chk("valid_during_redirect", 32'(instr_valid), 32'h0);
        @(posedge clk);
        #2;
        redirect = 1'b0;
    endtask

    // Memory model: in-order responses, lat cycles after grant.
    initial begin
        m_rvalid = 1'b0;
        m_rdata  = '0;
        cyc      = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mq.delete();
            end else begin
                if (imem_if.imem_rvalid) void'(mq.pop_front());
                if (imem_if.imem_req && imem_if.imem_gnt)
                    mq.push_back('{addr: imem_if.imem_addr, due: cyc + lat});
            end
            cyc++;
            #1;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                m_rvalid = 1'b1;
                m_rdata  = mem_word(mq[0].addr);
            end else begin
                m_rvalid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && imem_if.imem_req && imem_if.imem_gnt) begin
            grants++;
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL imem_addr: got grant at %h expected no request", imem_if.imem_addr);
            end else begin
                chk("imem_addr", imem_if.imem_addr, exp_addr.pop_front());
            end
        end
    end

    always @(negedge clk) begin : mon_instr
        logic [31:0] ep;
        logic [31:0] ew;
        if (rst_n && instr_valid && instr_ready) begin
            consumed++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL instr_unexpected: got pc %h expected none", pc);
            end else begin
                ep = exp_q.pop_front();
                ew = mem_word(ep);
                chk("pc",       pc,               ep);
                chk("pc_plus4", pc_plus4,         ep + 32'd4);
                chk("instr",    instr,            ew);
                chk("opc",      32'(opc),         32'(ew[6:0]));
                chk("funct3",   32'(funct3),      32'(ew[14:12]));
                chk("funct7",   32'(funct7),      32'(ew[30]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        int g0;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        gnt_en      = 1'b1;
        lat         = 1;

        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");

        // Sequential fetch from RESET_PC, first valid three edges after release.
        push_stream(32'h0, 64);
        rst_n = 1'b1;
        k = 0;
        while (k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (instr_valid) break;
        end
        chk("first_valid_latency", 32'(k), 32'd3);
        wait_consumed(16, "stream0_progress");

        // Decode stall: outputs hold, requests stop at the credit limit.
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (!instr_valid && k < 50);
        instr_ready = 1'b0;
        g0 = grants;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(instr_valid), 32'h1);
            chk("stall_pc",    pc,    exp_q[0]);
            chk("stall_instr", instr, mem_word(exp_q[0]));
            if (i == 4) chk("stall_req_low", 32'(imem_if.imem_req), 32'h0);
            @(posedge clk);
            #2;
        end
        chk("stall_grants_bounded", 32'(grants - g0 <= 2), 32'h1);
        instr_ready = 1'b1;
        base = consumed;
        wait_consumed(base + 8, "stream0_after_stall");

        // Grant stall with a redirect landing on the pending request.
        @(posedge clk);
        #2;
        gnt_en = 1'b0;
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (!imem_if.imem_req && k < 50);
        @(negedge clk);
        chk("gstall_req_c1",  32'(imem_if.imem_req), 32'h1);
        chk("gstall_addr_c1", imem_if.imem_addr,     exp_addr[0]);
        @(posedge clk);
        #2;
        do_redirect(32'h0000_0100, 32'h0000_0100);
        @(negedge clk);
        chk("gstall_req_c3",  32'(imem_if.imem_req), 32'h1);
        chk("gstall_addr_c3", imem_if.imem_addr,     exp_addr[0]);
        @(posedge clk);
        #2;
        gnt_en = 1'b1;
        base = consumed;
        wait_consumed(base + 8, "stream_100");

        // Misaligned redirect with two outstanding and a response in the same cycle.
        lat = 2;
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (!(mq.size() == 2 && imem_if.imem_rvalid && !imem_if.imem_req) && k < 100);
        chk("found_two_outstanding", 32'(mq.size()), 32'd2);
        do_redirect(32'h0000_0203, 32'h0000_0200);
        @(negedge clk);
        chk("drain_no_req", 32'(imem_if.imem_req), 32'h0);
        base = consumed;
        wait_consumed(base + 8, "stream_200");

        // Address wrap at the top of the address space.
        lat = 1;
        @(posedge clk);
        #2;
        do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8);
        base = consumed;
        wait_consumed(base + 6, "stream_wrap");

        // Asynchronous reset with requests in flight.
        lat = 2;
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (mq.size() != 2 && k < 100);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        exp_addr.delete();
        repeat (2) @(posedge clk);
        #2;
        lat = 1;
        push_stream(32'h0, 32);
        rst_n = 1'b1;
        base = consumed;
        wait_consumed(base + 8, "stream_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
